// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues one fetch at a time to instruction memory, holds the returned
// instruction for decode, and handles redirects (including misaligned
// targets) with a kill flag for responses that are still in flight.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic [63:0] pc_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        kill_q, kill_d;         // in-flight response must be discarded
  logic        fault_pend_q, fault_pend_d; // enter FAULT once the drain completes
  logic        misalign_q, misalign_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;

  logic        target_aligned;
  state_e      resume_state;

  assign target_aligned = (redirect_pc_i[1:0] == 2'b00);
  // stall_i only decides whether a fresh fetch starts right away.
  assign resume_state   = stall_i ? IDLE : REQ;

  // Next-state, PC and capture logic; redirect outranks every other event.
  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    kill_d       = kill_q;
    fault_pend_d = fault_pend_q;
    misalign_d   = misalign_q;

    if (redirect_i) begin
      pc_d       = redirect_pc_i;
      misalign_d = !target_aligned;
      unique case (state_q)
        REQ: begin
          if (imem_gnt_i) begin
            // Request was accepted this cycle: its response must be drained.
            state_d      = WAIT;
            kill_d       = 1'b1;
            fault_pend_d = !target_aligned;
          end else begin
            state_d = target_aligned ? REQ : FAULT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            // Response arrives with the redirect: drop it and move on.
            state_d      = target_aligned ? REQ : FAULT;
            kill_d       = 1'b0;
            fault_pend_d = 1'b0;
          end else begin
            kill_d       = 1'b1;
            fault_pend_d = !target_aligned;
          end
        end
        default: begin
          // IDLE, RESP (held instruction dropped) and FAULT.
          state_d = target_aligned ? resume_state : FAULT;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!stall_i) state_d = REQ;
        end
        REQ: begin
          // Address and request stay put until granted, regardless of stall_i.
          if (imem_gnt_i) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            kill_d       = 1'b0;
            fault_pend_d = 1'b0;
            if (kill_q) begin
              state_d = fault_pend_q ? FAULT : REQ;
            end else begin
              state_d   = RESP;
              inst_d    = imem_rdata_i;
              inst_pc_d = pc_q;
            end
          end
        end
        RESP: begin
          if (inst_ready_i) begin
            pc_d    = pc_q + 64'd4;
            state_d = resume_state;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign req_d   = (state_d == REQ);
  assign valid_d = (state_d == RESP);

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      kill_q       <= 1'b0;
      fault_pend_q <= 1'b0;
      misalign_q   <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      kill_q       <= kill_d;
      fault_pend_q <= fault_pend_d;
      misalign_q   <= misalign_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with a scoreboard of
// expected {pc, instruction} pairs pushed when a response is driven and
// popped when decode sees the instruction.
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst, stall_i, redirect_i, imem_gnt_i, imem_rvalid_i, inst_ready_i;
  logic [63:0] redirect_pc_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o, inst_valid_o, misalign_o;
  logic [63:0] imem_addr_o, inst_pc_o, pc_o;
  logic [31:0] inst_o;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_pc;
  int          errors = 0;
  int          checks = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .pc_o          (pc_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the request port against the bench's PC model.
  task automatic expect_req(input string name, input logic req_exp);
    checks++;
    if (imem_req_o !== req_exp || (req_exp && imem_addr_o !== model_pc)) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h, want req=%b addr=%h", name, imem_req_o,
               imem_addr_o, req_exp, model_pc);
    end
  endtask

  // Redirect from the current state, one-cycle strobe.
  task automatic do_redirect(input logic [63:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    step();
    redirect_i    = 1'b0;
  endtask

  // Full fetch starting in REQ: gnt after gnt_wait cycles, rvalid next cycle,
  // decode holds ready low for hold cycles, then accepts with stall_after.
  task automatic fetch_one(input int gnt_wait, input logic [31:0] data, input int hold,
                           input logic stall_after);
    exp_t e;
    expect_req("fetch_req", 1'b1);
    for (int i = 0; i < gnt_wait; i++) begin
      stall_i = ~stall_i;
      step();
      expect_req("req_held_no_gnt", 1'b1);
    end
    stall_i    = 1'b0;
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: req=%b valid=%b, want 0 0", imem_req_o, inst_valid_o);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    sb_q.push_back('{pc: model_pc, inst: data});
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    checks++;
    if (inst_valid_o !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL resp_valid: valid=%b sb=%0d, want valid=1", inst_valid_o, sb_q.size());
      e = '{pc: '0, inst: '0};
    end else begin
      e = sb_q.pop_front();
    end
    checks++;
    if (inst_o !== e.inst || inst_pc_o !== e.pc) begin
      errors++;
      $display("FAIL resp_data: inst=%h pc=%h, want inst=%h pc=%h", inst_o, inst_pc_o,
               e.inst, e.pc);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (inst_valid_o !== 1'b1 || inst_o !== e.inst || inst_pc_o !== e.pc ||
          imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold: valid=%b inst=%h pc=%h req=%b, want 1 %h %h 0",
                 inst_valid_o, inst_o, inst_pc_o, imem_req_o, e.inst, e.pc);
      end
    end
    inst_ready_i = 1'b1;
    stall_i      = stall_after;
    step();
    inst_ready_i = 1'b0;
    model_pc     = model_pc + 64'd4;
    checks++;
    if (inst_valid_o !== 1'b0 || pc_o !== model_pc) begin
      errors++;
      $display("FAIL accept: valid=%b pc=%h, want 0 %h", inst_valid_o, pc_o, model_pc);
    end
    expect_req("after_accept", !stall_after);
    if (stall_after) begin
      step();
      expect_req("idle_stalled", 1'b0);
      stall_i = 1'b0;
      step();
      expect_req("idle_release", 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0;
    step();
    step();
    checks++;
    if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || misalign_o !== 1'b0 ||
        pc_o !== RESET_PC || inst_o !== 32'h0 || inst_pc_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_values: req=%b valid=%b mis=%b pc=%h inst=%h ipc=%h",
               imem_req_o, inst_valid_o, misalign_o, pc_o, inst_o, inst_pc_o);
    end
    model_pc = RESET_PC;
    rst      = 1'b0;
    stall_i  = 1'b1;
    step();
    expect_req("stalled_after_reset", 1'b0);
    stall_i = 1'b0;
    step();
    expect_req("first_req", 1'b1);
  endtask

  task automatic test_basic();
    fetch_one(0, 32'h0000_0413, 0, 1'b0);
  endtask

  task automatic test_gnt_hold();
    fetch_one(3, 32'hdead_beef, 0, 1'b0);
  endtask

  task automatic test_resp_stall();
    fetch_one(0, 32'h1234_5678, 5, 1'b1);
  endtask

  task automatic test_redirect_req();
    do_redirect(64'h0000_0000_8000_2000);
    model_pc = 64'h0000_0000_8000_2000;
    expect_req("redirect_in_req", 1'b1);
    fetch_one(1, 32'h0011_2233, 0, 1'b0);
  endtask

  task automatic test_redirect_wait();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    do_redirect(64'h0000_0000_8000_1000);
    model_pc = 64'h0000_0000_8000_1000;
    expect_req("kill_wait_no_req", 1'b0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hbad0_0001;
    step();
    imem_rvalid_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL killed_resp: valid=%b, want 0", inst_valid_o);
    end
    expect_req("req_at_redirect", 1'b1);
  endtask

  task automatic test_redirect_wait_rvalid();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hbad0_0002;
    do_redirect(64'h0000_0000_8000_3000);
    imem_rvalid_i = 1'b0;
    model_pc      = 64'h0000_0000_8000_3000;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redirect_with_rvalid: valid=%b, want 0", inst_valid_o);
    end
    expect_req("req_after_redirect_rvalid", 1'b1);
  endtask

  task automatic test_redirect_resp();
    exp_t e;
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hcafe_f00d;
    sb_q.push_back('{pc: model_pc, inst: 32'hcafe_f00d});
    step();
    imem_rvalid_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL resp_before_redirect: valid=%b, want 1", inst_valid_o);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (inst_o !== e.inst || inst_pc_o !== e.pc) begin
        errors++;
        $display("FAIL resp_before_redirect_data: inst=%h pc=%h, want %h %h", inst_o,
                 inst_pc_o, e.inst, e.pc);
      end
    end
    inst_ready_i = 1'b1;
    do_redirect(64'h0000_0000_8000_4000);
    inst_ready_i = 1'b0;
    model_pc     = 64'h0000_0000_8000_4000;
    checks++;
    if (inst_valid_o !== 1'b0 || pc_o !== model_pc) begin
      errors++;
      $display("FAIL redirect_in_resp: valid=%b pc=%h, want 0 %h", inst_valid_o, pc_o,
               model_pc);
    end
    expect_req("req_after_resp_redirect", 1'b1);
  endtask

  task automatic test_misalign();
    do_redirect(64'h0000_0000_8000_0102);
    model_pc = 64'h0000_0000_8000_0102;
    checks++;
    if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== model_pc) begin
      errors++;
      $display("FAIL misalign_enter: mis=%b req=%b pc=%h, want 1 0 %h", misalign_o,
               imem_req_o, pc_o, model_pc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL fault_hold: mis=%b req=%b valid=%b, want 1 0 0", misalign_o,
                 imem_req_o, inst_valid_o);
      end
    end
    do_redirect(64'h0000_0000_8000_0200);
    model_pc = 64'h0000_0000_8000_0200;
    checks++;
    if (misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_exit: mis=%b, want 0", misalign_o);
    end
    expect_req("req_after_fault", 1'b1);
  endtask

  task automatic test_misalign_drain();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    do_redirect(64'h0000_0000_8000_0303);
    checks++;
    if (misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_misalign: mis=%b req=%b, want 1 0", misalign_o, imem_req_o);
    end
    step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hbad0_0003;
    step();
    imem_rvalid_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b0 || misalign_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_to_fault: valid=%b req=%b mis=%b, want 0 0 1", inst_valid_o,
               imem_req_o, misalign_o);
    end
    step();
    expect_req("fault_after_drain", 1'b0);
    do_redirect(64'h0000_0000_8000_0400);
    model_pc = 64'h0000_0000_8000_0400;
    expect_req("req_after_drain_fault", 1'b1);
  endtask

  task automatic test_wrap();
    do_redirect(64'hffff_ffff_ffff_fffc);
    model_pc = 64'hffff_ffff_ffff_fffc;
    fetch_one(0, 32'h0000_0013, 0, 1'b0);
    checks++;
    if (pc_o !== 64'h0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h, want 0", pc_o);
    end
  endtask

  task automatic test_reset_wait();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || misalign_o !== 1'b0 ||
        pc_o !== RESET_PC || inst_o !== 32'h0 || inst_pc_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_in_wait: req=%b valid=%b mis=%b pc=%h inst=%h ipc=%h",
               imem_req_o, inst_valid_o, misalign_o, pc_o, inst_o, inst_pc_o);
    end
    model_pc      = RESET_PC;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hbad0_0004;
    step();
    imem_rvalid_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_rvalid: valid=%b, want 0", inst_valid_o);
    end
    expect_req("req_after_reset_wait", 1'b1);
    fetch_one(0, 32'h0aa5_5aa0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_hold();
    test_resp_stall();
    test_redirect_req();
    test_redirect_wait();
    test_redirect_wait_rvalid();
    test_redirect_resp();
    test_misalign();
    test_misalign_drain();
    test_wrap();
    test_reset_wait();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_i  input  1  blocks issue of new fetch requests.
REQ-005 redirect_i  input  1  branch/jump redirect strobe, one cycle.
REQ-006 redirect_pc_i  input  64  redirect target address.
REQ-007 imem_req_o  output  1  fetch request valid.
REQ-008 imem_addr_o  output  64  fetch address, equals pc_o.
REQ-009 imem_gnt_i  input  1  request accepted this cycle.
REQ-010 imem_rvalid_i  input  1  response data valid.
REQ-011 imem_rdata_i  input  32  response instruction word.
REQ-012 inst_valid_o  output  1  instruction offered to decode.
REQ-013 inst_o  output  32  offered instruction.
REQ-014 inst_pc_o  output  64  address of offered instruction.
REQ-015 inst_ready_i  input  1  decode accepts offered instruction.
REQ-016 pc_o  output  64  current fetch PC.
REQ-017 misalign_o  output  1  redirect target not 4-byte aligned.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, RESP, FAULT.
REQ-019 IDLE: stall_i=0 -> REQ next cycle; stall_i=1 -> stay.
REQ-020 REQ: imem_req_o=1, imem_addr_o=pc_o held stable until imem_gnt_i; gnt -> WAIT.
REQ-021 stall_i SHALL NOT withdraw an asserted request; only gates IDLE->REQ and RESP->REQ.
REQ-022 WAIT: imem_rvalid_i=1 -> RESP capturing imem_rdata_i into inst_o and pc_o into inst_pc_o; imem_rvalid_i ignored in all other states.
REQ-023 RESP: inst_valid_o=1, inst_o/inst_pc_o stable until inst_ready_i=1.
REQ-024 RESP with inst_ready_i=1: pc_o <= pc_o+4 (64-bit, wraps modulo 2^64); next state REQ if stall_i=0, else IDLE.
REQ-025 Minimum latency: gnt in cycle N, rvalid in N+1 -> inst_valid_o in N+2.
REQ-026 Redirect has priority over every other event in the same cycle.
REQ-027 Aligned redirect (redirect_pc_i[1:0]==0) SHALL load pc_o <= redirect_pc_i next cycle.
REQ-028 Redirect in IDLE or RESP: next state REQ (IDLE if stall_i=1); held instruction dropped, inst_valid_o=0 next cycle; simultaneous inst_ready_i counts as accepted but pc_o takes target, not +4.
REQ-029 Redirect in REQ without gnt: request retargeted, stays REQ with new address.
REQ-030 Redirect in REQ with gnt same cycle, or in WAIT: set kill flag, go/stay WAIT; killed response discarded (no inst_valid_o), then REQ at target.
REQ-031 Redirect in WAIT same cycle as rvalid: response discarded, next state REQ at target.
REQ-032 Misaligned redirect (redirect_pc_i[1:0]!=0) from any state: pc_o <= redirect_pc_i, misalign_o=1 from next cycle, state FAULT; outstanding response still drained and discarded before entering FAULT.
REQ-033 FAULT: no requests, inst_valid_o=0, misalign_o=1; exit only on aligned redirect -> REQ/IDLE per stall_i, misalign_o=0.
REQ-034 Never more than one outstanding fetch.

Reset
REQ-035 rst=1 at posedge: state IDLE, pc_o=RESET_PC, inst_o=0, inst_pc_o=0, imem_req_o=0, inst_valid_o=0, misalign_o=0, kill flag cleared.
REQ-036 Reset mid-operation (any state) SHALL abandon outstanding fetch; memory side is reset in the same cycle.
REQ-037 First request SHALL assert the cycle after the first cycle with rst=0 and stall_i=0.

Verification
REQ-038 Reset release, stall_i=0, gnt immediate, rvalid next cycle with 32'h00000413 -> req addr 0x80000000, inst_valid_o with inst_pc_o 0x80000000, then req 0x80000004.
REQ-039 inst_ready_i held 0 for 5 cycles in RESP -> inst_o/inst_pc_o stable, no new imem_req_o.
REQ-040 Redirect to 0x80001000 in WAIT, rvalid next cycle -> no inst_valid_o, next req addr 0x80001000.
REQ-041 Redirect 0x80000102 -> misalign_o=1, no requests; then redirect 0x80000200 -> misalign_o=0, req at 0x80000200.
REQ-042 gnt withheld 3 cycles with stall_i toggling -> imem_req_o and address held constant until gnt.
REQ-043 rst asserted in WAIT -> next cycle IDLE, pc_o=0x80000000, all outputs at reset values.
